// File: rtl/pmem_burst_arbiter.sv
// Arbitrates icache/dcache line requests onto a four-beat burst memory port.
// Define PMEM_ARB_RR_EN for round-robin arbitration; the default is fixed dcache priority.
module pmem_burst_arbiter #(
   parameter int LINE_W = 256,
   parameter int BEAT_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_line_read,
   input  logic [31:0]       i_line_addr,
   output logic [LINE_W-1:0] i_line_rdata,
   output logic              i_line_resp,
   input  logic              d_line_read,
   input  logic              d_line_write,
   input  logic [31:0]       d_line_addr,
   input  logic [LINE_W-1:0] d_line_wdata,
   output logic [LINE_W-1:0] d_line_rdata,
   output logic              d_line_resp,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [31:0]       pmem_address,
   output logic [BEAT_W-1:0] pmem_wdata,
   input  logic [BEAT_W-1:0] pmem_rdata,
   input  logic              pmem_resp
);
   localparam int BEATS = LINE_W / BEAT_W;
   localparam int CNT_W = $clog2(BEATS);

   typedef enum logic [1:0] {ST_IDLE, ST_RD_BURST, ST_WR_BURST, ST_DONE} state_t;

   state_t            r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_inc;
   logic              r_owner_d;
   logic [LINE_W-1:0] r_buf;
   logic [31:0]       r_addr;
   logic [BEAT_W-1:0] r_wdata;
   logic              r_pmem_read, r_pmem_write, r_i_resp, r_d_resp;
   logic              w_d_req, w_pick_d, w_pick_i, w_grant, w_last_beat;

   assign w_d_req     = d_line_read | d_line_write;
   assign w_pick_i    = i_line_read & ~w_pick_d;
   assign w_grant     = w_pick_d | w_pick_i;
   assign w_last_beat = (r_cnt == CNT_W'(BEATS - 1));
   assign w_cnt_inc   = r_cnt + CNT_W'(1);

`ifdef PMEM_ARB_RR_EN
   logic r_last_owner_d;

   // On a tie the dcache wins only when the icache owned the port last.
   always_comb begin
      w_pick_d = w_d_req & (~i_line_read | ~r_last_owner_d);
   end

   // Remember which client was granted most recently.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last_owner_d <= 1'b0;
      end else if (r_state == ST_IDLE && w_grant) begin
         r_last_owner_d <= w_pick_d;
      end else begin
         r_last_owner_d <= r_last_owner_d;
      end
   end
`else
   // Fixed priority: dcache always beats icache.
   always_comb begin
      w_pick_d = w_d_req;
   end
`endif

   // Burst sequencing; a beat advances only on cycles with pmem_resp.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_pick_d && d_line_write) begin
               w_state_nxt = ST_WR_BURST;
            end else if (w_grant) begin
               w_state_nxt = ST_RD_BURST;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_RD_BURST, ST_WR_BURST: begin
            if (pmem_resp && w_last_beat) begin
               w_state_nxt = ST_DONE;
            end else begin
               w_state_nxt = r_state;
            end
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Datapath and registered outputs, all derived from the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt        <= '0;
         r_owner_d    <= 1'b0;
         r_buf        <= '0;
         r_addr       <= 32'd0;
         r_wdata      <= '0;
         r_pmem_read  <= 1'b0;
         r_pmem_write <= 1'b0;
         r_i_resp     <= 1'b0;
         r_d_resp     <= 1'b0;
      end else begin
         r_pmem_read  <= (w_state_nxt == ST_RD_BURST);
         r_pmem_write <= (w_state_nxt == ST_WR_BURST);
         r_i_resp     <= (w_state_nxt == ST_DONE) & ~r_owner_d;
         r_d_resp     <= (w_state_nxt == ST_DONE) &  r_owner_d;
         case (r_state)
            ST_IDLE: begin
               if (w_grant) begin
                  r_owner_d <= w_pick_d;
                  r_addr    <= (w_pick_d ? d_line_addr : i_line_addr) & 32'hFFFF_FFE0;
                  r_cnt     <= '0;
                  if (w_pick_d && d_line_write) begin
                     r_buf   <= d_line_wdata;
                     r_wdata <= d_line_wdata[BEAT_W-1:0];
                  end else begin
                     r_buf   <= r_buf;
                  end
               end else begin
                  r_cnt <= r_cnt;
               end
            end
            ST_RD_BURST: begin
               if (pmem_resp) begin
                  r_buf[r_cnt*BEAT_W +: BEAT_W] <= pmem_rdata;
                  r_cnt                         <= w_cnt_inc;
               end else begin
                  r_cnt <= r_cnt;
               end
            end
            ST_WR_BURST: begin
               if (pmem_resp) begin
                  r_cnt   <= w_cnt_inc;
                  r_wdata <= r_buf[w_cnt_inc*BEAT_W +: BEAT_W];
               end else begin
                  r_cnt <= r_cnt;
               end
            end
            default: begin
               r_cnt <= r_cnt;
            end
         endcase
      end
   end

   assign pmem_read    = r_pmem_read;
   assign pmem_write   = r_pmem_write;
   assign pmem_address = r_addr;
   assign pmem_wdata   = r_wdata;
   assign i_line_resp  = r_i_resp;
   assign d_line_resp  = r_d_resp;
   assign i_line_rdata = r_buf;
   assign d_line_rdata = r_buf;
endmodule
